// File: rtl/player_sprite.sv
`default_nettype none
// player_sprite: single Atari-style sprite with double-buffered position and scaled/reflected
// line drawing. Optional sticky collision flag under PLAYER_SPRITE_COLLISION_EN. Rev 1.0
module player_sprite #(
  parameter int SHAPE_ROWS = 16
) (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic       write_enable,
  input  logic [3:0] address,
  input  logic [7:0] data_in,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       in_image,
  input  logic       playfield_on,
  output logic       pixel_on,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       collision
);
  localparam int PTR_W = (SHAPE_ROWS > 1) ? $clog2(SHAPE_ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [7:0]       shape [SHAPE_ROWS];
  logic [PTR_W-1:0] ptr;
  logic [9:0]       xpos_s, ypos_s, xpos_a, ypos_a;
  logic             enable, reflect;
  logic [1:0]       scale;
  logic [7:0]       shift;
  state_t           state;
  logic [2:0]       bit_cnt, sub_cnt;

  logic             frame_start, line_start, in_band;
  logic [10:0]      v11, y11, height, v_off;
  logic [PTR_W-1:0] row;
  logic [2:0]       sub_max;
  logic             cur_draw, cur_pix;
  logic [2:0]       cur_bit, cur_sub;

  assign frame_start = (hpos == 10'd0) && (vpos == 10'd0);
  assign line_start  = (hpos == 10'd0);

  assign v11     = {1'b0, vpos};
  assign y11     = {1'b0, ypos_a};
  assign height  = 11'(SHAPE_ROWS) << scale;
  assign v_off   = v11 - y11;
  assign row     = PTR_W'(v_off >> scale);
  assign in_band = enable && (v11 >= y11) && (v11 < y11 + height);
  assign sub_max = 3'((4'd1 << scale) - 4'd1);

  // Shape RAM deliberately has no reset so its contents survive one.
  always_ff @(posedge raw_clk) begin
    if (write_enable && address == 4'd7)
      shape[ptr] <= data_in;
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      xpos_s  <= 10'd0;
      ypos_s  <= 10'd0;
      xpos_a  <= 10'd0;
      ypos_a  <= 10'd0;
      enable  <= 1'b0;
      reflect <= 1'b0;
      scale   <= 2'd0;
      shift   <= 8'h00;
      red     <= 8'h00;
      green   <= 8'h00;
      blue    <= 8'h00;
    end else begin
      if (write_enable) begin
        case (address)
          4'd0: xpos_s[7:0] <= data_in;
          4'd1: xpos_s[9:8] <= data_in[1:0];
          4'd2: ypos_s[7:0] <= data_in;
          4'd3: ypos_s[9:8] <= data_in[1:0];
          4'd4: begin
            red   <= {data_in[7:5], data_in[7:5], data_in[7:6]};
            green <= {data_in[4:2], data_in[4:2], data_in[4:3]};
            blue  <= {data_in[1:0], data_in[1:0], data_in[1:0], data_in[1:0]};
          end
          4'd5: begin
            enable  <= data_in[7];
            scale   <= data_in[2:1];
            reflect <= data_in[0];
          end
          4'd6: ptr <= PTR_W'(data_in[3:0]);
          4'd7: ptr <= ptr + 1'b1;
          default: ;
        endcase
      end
      if (frame_start) begin
        xpos_a <= xpos_s;
        ypos_a <= ypos_s;
      end
      if (line_start)
        shift <= in_band ? shape[row] : 8'h00;
    end
  end

  // Resolve the pixel under the beam now so the registered output has one cycle of latency;
  // the IDLE->DRAW hit is pixel 0. A sprite at x=0 is never drawn since hpos==0 forces IDLE.
  always_comb begin
    cur_draw = 1'b0;
    cur_bit  = 3'd0;
    cur_sub  = 3'd0;
    if (!line_start) begin
      if (state == DRAW) begin
        cur_draw = 1'b1;
        cur_bit  = bit_cnt;
        cur_sub  = sub_cnt;
      end else if (state == IDLE && hpos == xpos_a) begin
        cur_draw = 1'b1;
        cur_sub  = sub_max;
      end
    end
    cur_pix = reflect ? shift[cur_bit] : shift[3'd7 - cur_bit];
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      sub_cnt  <= 3'd0;
      pixel_on <= 1'b0;
    end else begin
      pixel_on <= cur_draw && cur_pix && in_image;
      if (line_start) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
        sub_cnt <= 3'd0;
      end else if (cur_draw) begin
        if (cur_sub == 3'd0) begin
          if (cur_bit == 3'd7) begin
            state <= DONE;
          end else begin
            state   <= DRAW;
            bit_cnt <= cur_bit + 3'd1;
            sub_cnt <= sub_max;
          end
        end else begin
          state   <= DRAW;
          bit_cnt <= cur_bit;
          sub_cnt <= cur_sub - 3'd1;
        end
      end
    end
  end

`ifdef PLAYER_SPRITE_COLLISION_EN
  logic pf_q;

  // pf_q lines playfield_on up with the registered pixel_on; a hit beats a clear.
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      pf_q      <= 1'b0;
      collision <= 1'b0;
    end else begin
      pf_q <= playfield_on;
      if (pixel_on && pf_q)
        collision <= 1'b1;
      else if (write_enable && address == 4'd8)
        collision <= 1'b0;
    end
  end
`else
  logic unused_playfield;
  assign unused_playfield = playfield_on;
  assign collision        = 1'b0;
`endif

endmodule
`default_nettype wire
